// File: rtl/ixc_assign_pipe.sv
// Valid/ready register pipeline of DEPTH stages moving R to L, with bubble collapsing,
// synchronous flush and an emulation force override on the output.
module ixc_assign_pipe #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned OCCW  = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] R,
    input  logic             R_valid,
    output logic             R_ready,
    output logic [WIDTH-1:0] L,
    output logic             L_valid,
    input  logic             L_ready,
    input  logic             flush,
    input  logic             frc_en,
    input  logic [WIDTH-1:0] frc_val,
    output logic [OCCW-1:0]  occ
);

    if (DEPTH == 0) begin : g_pass
        // No state, so clock, reset and flush have nothing to act on.
        logic unused_pass;
        assign unused_pass = ^{clk, rst_n, flush};

        always_comb begin
            R_ready = L_ready & ~frc_en;
            L       = frc_en ? frc_val : R;
            L_valid = R_valid & ~frc_en;
            occ     = '0;
        end
    end else begin : g_pipe
        logic [WIDTH-1:0] d_q [DEPTH];
        logic [WIDTH-1:0] d_d [DEPTH];
        logic [DEPTH-1:0] v_q;
        logic [DEPTH-1:0] v_d;
        logic [DEPTH-1:0] rdy;

        // A stage is ready if empty or if everything downstream can move.
        always_comb begin
            rdy = '0;
            rdy[DEPTH-1] = ~v_q[DEPTH-1] | L_ready;
            for (int k = 1; k < DEPTH; k++) begin
                rdy[DEPTH-1-k] = ~v_q[DEPTH-1-k] | rdy[DEPTH-k];
            end
        end

        always_comb begin
            v_d = v_q;
            d_d = d_q;
            if (flush) begin
                v_d = '0;
            end else if (!frc_en) begin
                if (rdy[0]) begin
                    v_d[0] = R_valid;
                    if (R_valid) d_d[0] = R;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (rdy[i]) begin
                        v_d[i] = v_q[i-1];
                        if (v_q[i-1]) d_d[i] = d_q[i-1];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= '0;
                for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end

        always_comb begin
            R_ready = rdy[0] & ~flush & ~frc_en;
            L       = frc_en ? frc_val : d_q[DEPTH-1];
            L_valid = v_q[DEPTH-1] & ~frc_en;
            occ     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                occ = occ + OCCW'(v_q[i]);
            end
        end
    end

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Self-checking bench: random and directed traffic on a DEPTH=2 pipe against a beat-queue
// model, plus directed checks of a DEPTH=3 stall/drain and the DEPTH=0 passthrough.
module tb_ixc_assign_pipe;

    localparam int unsigned DA = 2;

    logic clk;
    logic rst_n;

    logic [255:0] a_R, a_L, a_frc_val;
    logic         a_R_valid, a_R_ready, a_L_valid, a_L_ready, a_flush, a_frc_en;
    logic [1:0]   a_occ;

    logic [15:0]  b_R, b_L, b_frc_val;
    logic         b_R_valid, b_R_ready, b_L_valid, b_L_ready, b_flush, b_frc_en;
    logic [1:0]   b_occ;

    logic [7:0]   c_R, c_L, c_frc_val;
    logic         c_R_valid, c_R_ready, c_L_valid, c_L_ready, c_flush, c_frc_en;
    logic [0:0]   c_occ;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [255:0] data;
        int           age;
    } beat_t;
    beat_t q[$];

    ixc_assign_pipe #(.WIDTH(256), .DEPTH(DA)) u_a (
        .clk(clk), .rst_n(rst_n), .R(a_R), .R_valid(a_R_valid), .R_ready(a_R_ready),
        .L(a_L), .L_valid(a_L_valid), .L_ready(a_L_ready), .flush(a_flush),
        .frc_en(a_frc_en), .frc_val(a_frc_val), .occ(a_occ)
    );

    ixc_assign_pipe #(.WIDTH(16), .DEPTH(3)) u_b (
        .clk(clk), .rst_n(rst_n), .R(b_R), .R_valid(b_R_valid), .R_ready(b_R_ready),
        .L(b_L), .L_valid(b_L_valid), .L_ready(b_L_ready), .flush(b_flush),
        .frc_en(b_frc_en), .frc_val(b_frc_val), .occ(b_occ)
    );

    ixc_assign_pipe #(.WIDTH(8), .DEPTH(0)) u_c (
        .clk(clk), .rst_n(rst_n), .R(c_R), .R_valid(c_R_valid), .R_ready(c_R_ready),
        .L(c_L), .L_valid(c_L_valid), .L_ready(c_L_ready), .flush(c_flush),
        .frc_en(c_frc_en), .frc_val(c_frc_val), .occ(c_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock of DUT A: drive, check against the beat queue, then advance the model.
    // The oldest beat never waits on anything ahead of it, so it reaches the output
    // DEPTH-1 unfrozen edges after it was accepted.
    task automatic cycle_a(input logic rv, input logic [255:0] r, input logic lr,
                           input logic fl, input logic fe, input logic [255:0] fv);
        logic  exp_rr;
        logic  exp_lv;
        beat_t nb;
        a_R_valid = rv; a_R = r; a_L_ready = lr;
        a_flush = fl; a_frc_en = fe; a_frc_val = fv;
        @(negedge clk);
        exp_rr = ((q.size() < DA) || lr) && !fl && !fe;
        exp_lv = !fe && (q.size() > 0) && (q[0].age >= int'(DA) - 1);
        check("a_R_ready", 256'(a_R_ready), 256'(exp_rr));
        check("a_L_valid", 256'(a_L_valid), 256'(exp_lv));
        check("a_occ", 256'(a_occ), 256'(q.size()));
        if (fe) check("a_L_forced", a_L, fv);
        else if (exp_lv) check("a_L_data", a_L, q[0].data);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else if (!fe) begin
            if (exp_lv && lr) void'(q.pop_front());
            foreach (q[i]) q[i].age = q[i].age + 1;
            if (rv && exp_rr) begin
                nb.data = r;
                nb.age  = 0;
                q.push_back(nb);
            end
        end
        #1;
    endtask

    initial begin
        int idx;
        rst_n = 1'b0;
        a_R = '0; a_R_valid = 0; a_L_ready = 0; a_flush = 0; a_frc_en = 0; a_frc_val = '0;
        b_R = '0; b_R_valid = 0; b_L_ready = 0; b_flush = 0; b_frc_en = 0; b_frc_val = '0;
        c_R = '0; c_R_valid = 0; c_L_ready = 0; c_flush = 0; c_frc_en = 0; c_frc_val = '0;

        // Reset state
        #2;
        check("rst_L", a_L, '0);
        check("rst_L_valid", 256'(a_L_valid), 256'(0));
        check("rst_occ", 256'(a_occ), 256'(0));
        check("rst_R_ready", 256'(a_R_ready), 256'(1));
        check("rst_b_occ", 256'(b_occ), 256'(0));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back 0x01..0x10 with the sink always ready, then drain
        for (int i = 1; i <= 16; i++) cycle_a(1'b1, 256'(i), 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle_a(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

        // Fill while stalled, force all-ones for 4 cycles, then release and drain
        cycle_a(1'b1, 256'hAA, 1'b0, 1'b0, 1'b0, '0);
        cycle_a(1'b1, 256'hBB, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle_a(1'b1, 256'hCC, 1'b1, 1'b0, 1'b1, '1);
        for (int i = 0; i < 3; i++) cycle_a(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

        // Flush with two beats in flight and a concurrent offered beat
        cycle_a(1'b1, 256'h11, 1'b0, 1'b0, 1'b0, '0);
        cycle_a(1'b1, 256'h22, 1'b0, 1'b0, 1'b0, '0);
        cycle_a(1'b1, 256'h33, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle_a(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

        // Random traffic with occasional stalls, flushes and forces
        for (int i = 0; i < 400; i++) begin
            cycle_a(($urandom_range(0, 3) != 0), rand256(), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), rand256());
        end
        for (int i = 0; i < 3; i++) cycle_a(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

        // DEPTH=3: five beats against a stalled sink, then drain in order
        b_L_ready = 1'b0;
        b_R_valid = 1'b1;
        idx = 0;
        b_R = 16'h0101;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            check("b_fill_R_ready", 256'(b_R_ready), 256'(cyc < 3));
            if (cyc >= 3) begin
                check("b_full_occ", 256'(b_occ), 256'(3));
                check("b_full_L_valid", 256'(b_L_valid), 256'(1));
                check("b_full_L", 256'(b_L), 256'(16'h0101));
            end
            @(posedge clk);
            #1;
            if (cyc < 3) begin
                idx++;
                b_R = 16'(16'h0101 + idx);
            end
        end
        b_L_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("b_drain_L_valid", 256'(b_L_valid), 256'(1));
            check("b_drain_L", 256'(b_L), 256'(16'h0101 + k));
            check("b_drain_R_ready", 256'(b_R_ready), 256'(1));
            @(posedge clk);
            #1;
            if (b_R_valid) begin
                idx++;
                if (idx == 5) b_R_valid = 1'b0;
                else b_R = 16'(16'h0101 + idx);
            end
        end
        @(negedge clk);
        check("b_empty_L_valid", 256'(b_L_valid), 256'(0));
        check("b_empty_occ", 256'(b_occ), 256'(0));
        @(posedge clk);
        #1;

        // DEPTH=0 passthrough
        c_R = 8'h3C; c_R_valid = 1'b1; c_L_ready = 1'b0;
        #1;
        check("c_L", 256'(c_L), 256'(8'h3C));
        check("c_L_valid", 256'(c_L_valid), 256'(1));
        check("c_R_ready_stall", 256'(c_R_ready), 256'(0));
        check("c_occ", 256'(c_occ), 256'(0));
        c_L_ready = 1'b1; c_flush = 1'b1;
        #1;
        check("c_R_ready_flush_ignored", 256'(c_R_ready), 256'(1));
        c_frc_en = 1'b1; c_frc_val = 8'h5A;
        #1;
        check("c_forced_L", 256'(c_L), 256'(8'h5A));
        check("c_forced_L_valid", 256'(c_L_valid), 256'(0));
        check("c_forced_R_ready", 256'(c_R_ready), 256'(0));
        c_frc_en = 1'b0; c_flush = 1'b0;

        // Asynchronous reset between edges with beats in flight
        cycle_a(1'b1, 256'h71, 1'b0, 1'b0, 1'b0, '0);
        cycle_a(1'b1, 256'h72, 1'b0, 1'b0, 1'b0, '0);
        a_R_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_L", a_L, '0);
        check("arst_L_valid", 256'(a_L_valid), 256'(0));
        check("arst_occ", 256'(a_occ), 256'(0));
        q.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle_a(1'b1, 256'hA5, 1'b1, 1'b0, 1'b0, '0);
        cycle_a(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        cycle_a(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ixc_assign_pipe.md
# ixc_assign_pipe

Parametrised successor to the fixed-width per-bit assign template in IXCOM_TEMP_LIBRARY. It moves a WIDTH-bit vector from R to L through DEPTH valid/ready register stages, with bubble collapsing, a synchronous flush and an emulation force override. It sits on wide emulator datapaths where a pure assign must be retimed without breaking the handshake.

## Interface
- WIDTH, 256: data width in bits, 1..1024.
- DEPTH, 2: number of register stages, 0..8; 0 = combinational passthrough.
- OCCW, $clog2(DEPTH+1) (min 1): width of occ.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset (one clock; async active-low reset).
- R  in  WIDTH  source data.
- R_valid  in  1  source data valid.
- R_ready  out  1  block can accept R this cycle.
- L  out  WIDTH  destination data.
- L_valid  out  1  L holds valid data.
- L_ready  in  1  sink accepts L this cycle.
- flush  in  1  synchronous clear of all stage valids.
- frc_en  in  1  force override active.
- frc_val  in  WIDTH  value driven on L while forced.
- occ  out  OCCW  number of valid stages.

## Operation
- Stages s0 (input) .. s[DEPTH-1] (output). Each stage holds d[i] (WIDTH) and v[i].
- Stage ready: rdy[DEPTH-1] = !v[DEPTH-1] | L_ready; rdy[i] = !v[i] | rdy[i+1]. Bubbles collapse, so any empty stage accepts even when the sink stalls.
- R_ready = rdy[0] & !flush & !frc_en.
- Stage i loads from stage i-1 (s0 from R) when rdy[i] & !flush & !frc_en. v[i] <= upstream valid; d[i] loads only when upstream valid is 1, so data holds on bubbles.
- L = d[DEPTH-1], L_valid = v[DEPTH-1] unless forced.
- Force: while frc_en=1, L = frc_val and L_valid = 0. The pipeline is frozen: no loads, no drains, R_ready = 0. Contents resume unchanged when frc_en drops.
- Flush: when flush=1 at a clock edge, all v[i] <= 0 and d[i] hold. The input is not accepted that cycle. Flush wins over R_valid, L_ready and frc_en.
- occ = popcount(v). It is registered-state derived, never exceeds DEPTH, and flush takes it to 0 on the next cycle.
- DEPTH=0: L = R, L_valid = R_valid, R_ready = L_ready. flush is ignored. Force still applies (R_ready=0, L=frc_val, L_valid=0). occ = 0.
- No X propagation allowed from d[] on reset; data is pure copy, with no width conversion.

## Timing
- Reset (rst_n=0, asynchronous): all v[i]=0, all d[i]=0. Outputs: L=0 (or frc_val if frc_en), L_valid=0, occ=0, R_ready=1 if !flush & !frc_en.
- Latency: a beat accepted at edge n appears on L_valid after DEPTH edges through an empty pipe, i.e. visible in cycle n+DEPTH-1 after acceptance.
- Throughput: 1 beat/cycle while L_ready=1.
- Full: all v=1 and L_ready=0 -> R_ready=0. Entry and exit happen in the same cycle when L_ready=1.
- R_ready, L, L_valid and occ are combinational from state and the inputs above. The ready path is combinational through the chain, with depth DEPTH.
- Reset asserted mid-transfer discards all beats immediately. The first accept is possible on the first edge after rst_n rises.
- Handshake rules:
  - A beat transfers on R when R_valid & R_ready at an edge, and on L when L_valid & L_ready.
  - Once L_valid=1 with L_ready=0, L and L_valid must hold stable until the transfer or a flush (force masks but does not alter them).

## Test plan
- DEPTH=2, WIDTH=256, L_ready=1: send 0x01..0x10 back-to-back -> same 16 values in order on L, first L_valid 1 cycle after the first accept, no gaps, occ steady at 2.
- DEPTH=3: hold L_ready=0 and send 5 beats -> R_ready drops after 3 accepts, occ=3, L=first beat held stable. Raise L_ready -> remaining beats drain in order.
- DEPTH=2: flush asserted in the same cycle as R_valid=1 with 2 beats in flight -> next cycle occ=0, L_valid=0, the concurrent beat is not accepted and never appears.
- DEPTH=2: frc_en=1 with frc_val=all-ones for 4 cycles while the pipe is full -> L=all-ones, L_valid=0, R_ready=0. After release, the original beats emerge unchanged.
- Reset asserted asynchronously mid-stream (between edges) -> L=0, L_valid=0 and occ=0 immediately. After release, a new beat 0xA5 emerges after DEPTH edges.
- DEPTH=0, WIDTH=8: R=0x3C, R_valid=1, L_ready=0 -> L=0x3C and L_valid=1 in the same cycle, R_ready=0, occ=0.
